alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one 32-bit `alu` datapath among `NREQ` independent requesters. Each requester presents an operation (`a`, `b`, `ALUControl`) over a valid/ready handshake. The arbiter grants one request at a time in round-robin order, registers the operands, and runs the shared `alu`. It then returns the registered `Result` and `ALUFlags` to the granted requester over a per-requester response handshake. It sits between the decode/issue logic and the single ALU instance, so several issue sources can time-multiplex it.

## Interface
- `NREQ`, default 4: number of requesters; legal range 1..8. Grant index width is `GW = max(1, $clog2(NREQ))`.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle; one-hot or zero.
- `req_a` in NREQ×32: operand A per requester.
- `req_b` in NREQ×32: operand B per requester.
- `req_ctrl` in NREQ×2: ALUControl per requester.
- `rsp_valid` out NREQ: response available; one-hot or zero.
- `rsp_ready` in NREQ: requester consumes its response.
- `rsp_result` out 32: registered ALU result, shared by all requesters.
- `rsp_flags` out 4: registered {N,Z,C,V}, shared by all requesters.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first set bit at or after `rr_ptr`, searching upward with wrap from NREQ-1 to 0.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch `a`, `b`, `ctrl` and `owner=g` into operand registers, then go to EXEC.
  - With no valid requests, stay in IDLE.
- **EXEC:** the `alu` sees the registered operands. At the clock edge, latch `Result` into `rsp_result` and `ALUFlags` into `rsp_flags`, then go to RESP.
- **RESP:**
  - Drive `rsp_valid[owner]=1`.
  - When `rsp_ready[owner]` is high, set `rr_ptr = owner+1` (wrapping to 0 after NREQ-1) and go to IDLE.
  - `rsp_ready` from non-owners is ignored.
- `req_ready` is zero outside IDLE. A new request is never accepted in the same cycle a response completes.
- Operands are sampled only on the accept edge. Later changes to `req_*` do not affect an operation in flight.
- Requesters must hold `req_valid` and their operands stable until `req_ready`. If a requester drops `req_valid` before being granted, it simply is not considered.
- ALUControl encodings: 00 ADD, 01 SUB (a + ~b + 1), 10 AND, 11 OR.
- Flags:
  - N = Result[31].
  - Z = (Result == 0).
  - C = carry-out of bit 31; zero for AND/OR.
  - V = signed overflow; zero for AND/OR.
- Results are modulo 2^32.
- NREQ=1: the arbiter degenerates to a 3-state sequencer and `rr_ptr` stays 0.

## Timing
- Reset (asynchronous assert while `reset_n`=0):
  - State returns to IDLE and `rr_ptr` to 0.
  - Operand registers, `owner`, `rsp_result` and `rsp_flags` clear to 0.
  - `req_ready`, `rsp_valid` and `busy` are 0.
- Reset mid-operation discards the in-flight operation with no response. Operation resumes on the first edge after `reset_n` deasserts.
- Latency: accept at edge T (end of the IDLE cycle) gives `rsp_valid` high in the cycle following edge T+1. This is 2 cycles from accept to response.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, RESP). Each extra cycle of `rsp_ready` low extends RESP by 1.
- `rsp_result`/`rsp_flags` stay stable for the whole of RESP and hold their value afterwards until the next EXEC edge.

## Structure
- Package `alu_pkg`:
  - ALUControl encodings `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`.
  - Flag bit indices `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - FSM enum `arb_state_t`.
- Sub-modules:
  - One instance of the existing `alu`, driven from the operand registers.
  - `rr_pick` (round-robin first-set-from-pointer, combinational) is natural as a separate sub-module.

## Test plan
- **Single ADD:** requester 0 sends a=7, b=5, ctrl=00 with `rsp_ready` tied high. Expect `req_ready[0]` in the same cycle, `rsp_valid[0]` 2 cycles later, result 12, flags 0000.
- **SUB zero and overflow:**
  - Requester 2 sends 5-5. Expect result 0, flags 0110 (Z, C).
  - Then 0x7FFFFFFF+1. Expect 0x80000000, flags 1001 (N, V).
- **Round-robin:** all 4 requesters hold valid with `rsp_ready` high. Expect grant order 0,1,2,3,0 and an accept every 3 cycles. After granting 3, requester 0 wins over a newly raised requester 1.
- **Backpressure:** requester 1 sends OR 0xF0F0_0000 | 0x0000_0F0F. `rsp_ready[1]` stays low for 5 cycles while `rsp_ready[0]` is high. Expect `rsp_valid[1]` held with result 0xF0F0_0F0F, flags 1000, no new `req_ready`, `busy`=1.
- **Reset mid-op:** pull `reset_n` low during EXEC. Expect `rsp_valid`=0, `busy`=0 and `rsp_result`=0 immediately (asynchronously). After release, requester 3's pending request is granted first because `rr_ptr` is 0 and requester 3 is the only valid one.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, flag bit positions and arbiter FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue sources and the shared ALU arbiter.
interface alu_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][31:0]  req_a;
  logic [NREQ-1:0][31:0]  req_b;
  logic [NREQ-1:0][1:0]   req_ctrl;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [31:0]            rsp_result;
  logic [3:0]             rsp_flags;

  // requester side
  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  // arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu.sv
// 32-bit ALU: ADD, SUB, AND, OR with {N,Z,C,V} flags.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ALUControl,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags
);

  logic [31:0] bx;
  logic [32:0] sum;
  logic        cy, ov;

  // SUB reuses the adder as a + ~b + 1
  assign bx  = ALUControl[0] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {32'b0, ALUControl[0]};

  // result select; carry/overflow only meaningful for arithmetic ops
  always_comb begin
    Result = sum[31:0];
    cy     = 1'b0;
    ov     = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        Result = sum[31:0];
        cy     = sum[32];
        ov     = (a[31] == bx[31]) && (sum[31] != a[31]);
      end
      ALU_AND: Result = a & b;
      default: Result = a | b;
    endcase
  end

  // flag packing
  always_comb begin
    ALUFlags         = '0;
    ALUFlags[FLAG_N] = Result[31];
    ALUFlags[FLAG_Z] = (Result == 32'd0);
    ALUFlags[FLAG_C] = cy;
    ALUFlags[FLAG_V] = ov;
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          vld,
  output logic [GW-1:0] idx
);

  localparam logic [GW:0] NV = (GW+1)'(N);

  logic [GW:0] s;

  // walk N slots from ptr; the first hit wins
  always_comb begin
    vld = 1'b0;
    idx = '0;
    s   = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (GW+1)'(k);
      if (s >= NV) s = s - NV;
      if (!vld && req[s[GW-1:0]]) begin
        vld = 1'b1;
        idx = s[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-multiplexes one ALU among NREQ requesters, one op at a time, round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW-1:0] LAST = GW'(NREQ - 1);

  arb_state_t    state;
  logic [GW-1:0] rr_ptr, owner, pick_idx;
  logic          pick_vld, rsp_done;
  logic [31:0]   op_a, op_b, alu_res, res_q;
  logic [1:0]    op_ctrl;
  logic [3:0]    alu_flags, flags_q;

  rr_pick #(.N(NREQ), .GW(GW)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  alu u_alu (
    .a          (op_a),
    .b          (op_b),
    .ALUControl (op_ctrl),
    .Result     (alu_res),
    .ALUFlags   (alu_flags)
  );

  assign rsp_done       = (state == ST_RESP) && bus.rsp_ready[owner];
  assign busy           = (state != ST_IDLE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flags_q;

  // grant is combinational in IDLE; held off while reset is asserted
  always_comb begin
    bus.req_ready = '0;
    if (reset_n && state == ST_IDLE && pick_vld) bus.req_ready[pick_idx] = 1'b1;
  end

  // response strobe goes only to the requester that owns the op
  always_comb begin
    bus.rsp_valid = '0;
    if (state == ST_RESP) bus.rsp_valid[owner] = 1'b1;
  end

  // sequencer: accept -> execute -> hold response until consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_vld) begin
          op_a    <= bus.req_a[pick_idx];
          op_b    <= bus.req_b[pick_idx];
          op_ctrl <= bus.req_ctrl[pick_idx];
          owner   <= pick_idx;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_res;
          flags_q <= alu_flags;
          state   <= ST_RESP;
        end
        ST_RESP: if (rsp_done) begin
          rr_ptr <= (owner == LAST) ? '0 : owner + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       v, rr;
  logic [NREQ-1:0][31:0] av, bv;
  logic [NREQ-1:0][1:0]  cv;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();
  assign bus.req_valid = v;
  assign bus.req_a     = av;
  assign bus.req_b     = bv;
  assign bus.req_ctrl  = cv;
  assign bus.rsp_ready = rr;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  // model: at most one op owned; response pending once computed
  int          m_owner = -1, m_ptr = 0;
  logic        m_resp = 1'b0;
  logic [31:0] m_a, m_b, m_res = '0;
  logic [1:0]  m_c;
  logic [3:0]  m_flags = '0;

  logic [NREQ-1:0] s_ready, s_rvalid;
  logic [31:0]     s_res;
  logic [3:0]      s_flags;
  logic            s_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [35:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] op);
    longint sx, sy, ss;
    logic [31:0] r;
    logic cy, ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ss = 0; cy = 1'b0; ov = 1'b0;
    case (op)
      2'd0: begin
        r  = x + y;
        cy = (longint'(x) + longint'(y)) > 64'sd4294967295;
        ss = sx + sy;
        ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'd1: begin
        r  = x - y;
        cy = (x >= y);
        ss = sx - sy;
        ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'd2:    r = x & y;
      default: r = x | y;
    endcase
    return {r[31], r == 32'd0, cy, ov, r};
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // one clock: sample + compare at negedge, advance model, return at posedge+1
  task automatic step();
    int win;
    logic [NREQ-1:0] er, ev;
    @(negedge clk);
    s_ready = bus.req_ready; s_rvalid = bus.rsp_valid;
    s_res = bus.rsp_result; s_flags = bus.rsp_flags; s_busy = busy;
    win = -1; er = '0; ev = '0;
    if (reset_n && m_owner < 0)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (win < 0 && v[j]) win = j;
      end
    if (win >= 0) er[win] = 1'b1;
    if (m_owner >= 0 && m_resp) ev[m_owner] = 1'b1;
    chk("req_ready", 64'(s_ready), 64'(er));
    chk("rsp_valid", 64'(s_rvalid), 64'(ev));
    chk("busy", 64'(s_busy), 64'(m_owner >= 0));
    chk("rsp_result", 64'(s_res), 64'(m_res));
    chk("rsp_flags", 64'(s_flags), 64'(m_flags));
    if (reset_n) begin
      if (win >= 0) begin
        m_owner = win; m_resp = 1'b0;
        m_a = av[win]; m_b = bv[win]; m_c = cv[win];
      end else if (m_owner >= 0 && !m_resp) begin
        {m_flags, m_res} = ref_alu(m_a, m_b, m_c);
        m_resp = 1'b1;
      end else if (m_owner >= 0 && rr[m_owner]) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1; m_resp = 1'b0;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // issue one op, wait for accept and response, check latency and values
  task automatic do_op(input string tag, input int idx, input logic [31:0] x,
                       input logic [31:0] y, input logic [1:0] op,
                       input logic [31:0] er, input logic [3:0] ef);
    bit got;
    int lat;
    av[idx] = x; bv[idx] = y; cv[idx] = op; v[idx] = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      step();
      if (s_ready[idx]) got = 1;
    end
    chk({tag, "_accept"}, 64'(got), 64'd1);
    v[idx] = 1'b0;
    got = 0; lat = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      step(); lat++;
      if (s_rvalid[idx]) got = 1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    chk({tag, "_result"}, 64'(s_res), 64'(er));
    chk({tag, "_flags"}, 64'(s_flags), 64'(ef));
  endtask

  int g_idx[$], g_cyc[$];

  initial begin
    v = '0; rr = '0; av = '0; bv = '0; cv = '0;
    // reset state, with a request present to show it is not granted
    v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_flags", 64'(bus.rsp_flags), 64'd0);
    v[0] = 1'b0;
    reset_n = 1'b1;
    rr = '1;

    do_op("add", 0, 32'd7, 32'd5, 2'b00, 32'd12, 4'b0000);
    do_op("sub0", 2, 32'd5, 32'd5, 2'b01, 32'd0, 4'b0110);
    do_op("ovf", 2, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001);
    do_op("r3", 3, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 4'b0110);

    // round-robin with all requesters valid and always ready
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 32'(i + 1); bv[i] = 32'd3; cv[i] = 2'b10;
    end
    v = '1;
    for (int t = 0; t < 40 && g_idx.size() < 5; t++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (s_ready[i]) begin
        g_idx.push_back(i); g_cyc.push_back(cyc);
      end
    end
    chk("rr_count", 64'(g_idx.size()), 64'd5);
    if (g_idx.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(g_idx[i]), 64'(i % NREQ));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
    end
    v = '0;
    repeat (4) step();

    // backpressure on requester 1 while requester 0 waits
    rr = 4'b1101;
    do_op("bp", 1, 32'hF0F0_0000, 32'h0000_0F0F, 2'b11, 32'hF0F0_0F0F, 4'b1000);
    av[0] = 32'd1; bv[0] = 32'd1; cv[0] = 2'b00; v[0] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("bp_rvalid", 64'(s_rvalid), 64'b0010);
      chk("bp_ready", 64'(s_ready), 64'd0);
      chk("bp_busy", 64'(s_busy), 64'd1);
      chk("bp_result", 64'(s_res), 64'hF0F0_0F0F);
    end
    rr = '1;
    step();
    step();
    chk("bp_next_grant", 64'(s_ready), 64'b0001);

    // now in EXEC for requester 0: reset asynchronously
    v[0] = 1'b0; v[3] = 1'b1;
    av[3] = 32'd9; bv[3] = 32'd4; cv[3] = 2'b01;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rvalid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", 64'(bus.rsp_result), 64'd0);
    m_owner = -1; m_resp = 1'b0; m_ptr = 0; m_res = '0; m_flags = '0;
    step();
    reset_n = 1'b1;
    step();
    chk("arst_first_grant", 64'(s_ready), 64'b1000);
    v[3] = 1'b0;
    repeat (3) step();

    // randomized traffic
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1; av[i] = rand_word(); bv[i] = rand_word();
          cv[i] = 2'($urandom_range(0, 3));
        end else if (v[i] && $urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      step();
      v = v & ~s_ready;
    end
    v = '0; rr = '1;
    repeat (6) step();
    chk("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
